in_port: RTL
============

# in_port

Processor-side input block, the counterpart of the 7-segment output path. It synchronizes the 16 DIP switches and the ENTER push button, debounces the button, and serves the processor's IN request. On a request it stalls the processor until a fresh button press, then captures the switch word and returns it with a one-cycle valid pulse.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 250000: cycles the synchronized button must stay stable before the debounced level changes. Must be ≥1 and < 2^CNT_W.
- CNT_W, default 20: width of the debounce counter.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
- sw  input  16  raw DIP switches; asynchronous to clock.
- btn_enter  input  1  raw ENTER button, active-high; asynchronous, bouncy.
- inreq  input  1  processor IN request (level); held high until invalid is seen.
- inval  output  16  last captured switch word; holds its value between captures.
- invalid  output  1  one-cycle pulse: inval was updated for the current request.
- inbusy  output  1  high while waiting for a press; the processor stalls on it.

## Operation
- Synchronizers: sw and btn_enter each pass through two flops, giving sw_sync and btn_sync. Reset value 0.
- Debounce: registers btn_db and cnt[CNT_W-1:0].
  - If btn_sync == btn_db: cnt ← 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1: btn_db ← btn_sync and cnt ← 0.
  - Else: cnt ← cnt+1.
  - Any bounce that restores equality restarts the count.
- Edge: btn_db_d is btn_db delayed one cycle. press = btn_db & ~btn_db_d, so each press gives exactly one pulse. A release gives no pulse.
- FSM states:
  - IDLE: inbusy=0. If inreq=1, go to WAIT.
  - WAIT: inbusy=1.
    - If inreq=0, abort to IDLE; no capture, no invalid.
    - Else if press=1: inval ← sw_sync, go to DONE.
  - DONE: invalid=1, inbusy=0. If inreq=0, go to IDLE; else go to HOLD.
  - HOLD: inbusy=0, invalid=0. Go to IDLE when inreq=0. This prevents a still-high inreq from re-triggering.
- A press in IDLE, DONE or HOLD is discarded, not queued.
- invalid and inbusy are decoded from the registered state only (glitch-free, no combinational path from inputs).
- Reset values: state=IDLE, inval=0, invalid=0, inbusy=0, cnt=0, btn_db=0, btn_db_d=0, all synchronizer flops 0.

## Timing
- Button latency: a clean level change on btn_enter reaches btn_sync after 2 edges.
  - btn_db follows DEBOUNCE_CYCLES edges later.
  - press is high in the cycle after the btn_db edge.
- Capture: if the press cycle falls in WAIT, the next edge loads inval and enters DONE.
  - invalid and the new inval are visible together, for exactly one cycle.
- Request latency: inreq sampled high in IDLE → inbusy high in the next cycle.
- Simultaneous events:
  - inreq rising in the same cycle as press while in IDLE: the press is ignored; WAIT needs a new press.
  - inreq falling in the same cycle as press while in WAIT: abort wins; inval is unchanged.
- Reset mid-operation: any state returns to IDLE on the next edge. The pending request is dropped, inval is cleared to 0, and no invalid is issued.
- Captured value is sw_sync at the capture edge, i.e. the switches as they were 2 cycles earlier.

## Configuration
- IN_DEBOUNCE_EN defined: debounce counter as specified.
- IN_DEBOUNCE_EN undefined:
  - cnt is absent and DEBOUNCE_CYCLES is ignored.
  - btn_db ← btn_sync every cycle, so press appears 1 cycle after the btn_sync rise.
  - All FSM behaviour is unchanged.

## Test plan
- Basic read (DEBOUNCE_CYCLES=4, IN_DEBOUNCE_EN): sw=16'hBEEF, inreq=1, clean press → inbusy high until capture; one invalid pulse with inval=16'hBEEF; inbusy=0 afterwards.
- Bounce rejection: btn_enter toggles 1,0,1,0 with each level lasting 3 cycles (< 4), then stays high → exactly one press; one capture only after 4 stable cycles.
- Held request: inreq stays high 10 cycles after invalid; a second press during HOLD → no second invalid; inval is unchanged.
- Abort: inreq=1, wait 5 cycles, then inreq=0 with press in the same cycle → state IDLE, invalid never asserted, inval keeps its prior value.
- Ignored press: press in IDLE, then inreq=1 with sw=16'h1234 → inbusy stays high until a new press, which yields inval=16'h1234.
- Reset mid-WAIT: reset high for 1 cycle while in WAIT → inval=0, inbusy=0, invalid=0. A later press with inreq=0 produces nothing.

Source files
------------

// File: rtl/in_port.sv
// Processor IN port: synchronizes switches and ENTER, debounces ENTER, and serves IN requests.
// Define IN_DEBOUNCE_EN to enable the debounce counter; otherwise btn_db follows btn_sync.
module in_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] sw,
    input  logic        btn_enter,
    input  logic        inreq,
    output logic [15:0] inval,
    output logic        invalid,
    output logic        inbusy
);

    typedef enum logic [1:0] {StIdle, StWait, StDone, StHold} state_e;

    state_e      state;
    logic [15:0] sw_meta;
    logic [15:0] sw_sync;
    logic        btn_meta;
    logic        btn_sync;
    logic        btn_db;
    logic        btn_db_d;
    logic        press;

    if (DEBOUNCE_CYCLES < 1 || CNT_W < 1 ||
        64'(DEBOUNCE_CYCLES) >= (64'(1) << CNT_W)) begin : g_cfg_check
        $error("in_port: DEBOUNCE_CYCLES must be >= 1 and fit in CNT_W bits");
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= btn_enter;
            btn_sync <= btn_meta;
        end
    end

`ifdef IN_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Any return to equality restarts the stability count.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            btn_db <= 1'b0;
        end else if (btn_sync == btn_db) begin
            cnt <= '0;
        end else if (cnt == CntMax) begin
            btn_db <= btn_sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_db <= 1'b0;
        end else begin
            btn_db <= btn_sync;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_db_d <= 1'b0;
        end else begin
            btn_db_d <= btn_db;
        end
    end

    assign press = btn_db & ~btn_db_d;

    // Outputs are registered with the state so they never glitch on input changes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= StIdle;
            inval   <= '0;
            invalid <= 1'b0;
            inbusy  <= 1'b0;
        end else begin
            invalid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (inreq) begin
                        state  <= StWait;
                        inbusy <= 1'b1;
                    end
                end
                StWait: begin
                    if (!inreq) begin
                        state  <= StIdle;
                        inbusy <= 1'b0;
                    end else if (press) begin
                        inval   <= sw_sync;
                        state   <= StDone;
                        inbusy  <= 1'b0;
                        invalid <= 1'b1;
                    end
                end
                // HOLD keeps a still-high inreq from starting a second read.
                StDone: state <= inreq ? StHold : StIdle;
                StHold: begin
                    if (!inreq) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state  <= StIdle;
                    inbusy <= 1'b0;
                end
            endcase
        end
    end

endmodule
